sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
- Synthesizable, parametrised successive-approximation controller for the SAR ADC tile.
- Sequences sample and convert phases and drives the capacitor-DAC trial code from an external comparator decision, one bit per cycle.
- Scans a masked set of input channels in single-shot or continuous mode.
- Presents each result with its channel tag on a valid/ready interface with overrun detection.

Parameters:
- WIDTH, 8, conversion resolution in bits (2..16).
- NCH, 4, number of analog input channels (1..16). CHW = max(1, clog2(NCH)).
- SAMPLE_CYCLES, 2, clock cycles the sample switch is held closed (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  block enable. Low forces OFF on the next edge.
- start  in  1  begin a scan. Honoured only in OFF.
- cont  in  1  continuous mode; latched at start.
- ch_mask  in  NCH  channels to convert; latched at start.
- cmp  in  1  comparator: 1 = vin >= DAC trial level.
- sample  out  1  sample-switch enable.
- ch_sel  out  CHW  analog mux select.
- dac_code  out  WIDTH  DAC trial code.
- busy  out  1  state != OFF.
- result  out  WIDTH  last completed code.
- result_ch  out  CHW  channel of result.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- overrun  out  1  sticky: an unconsumed result was overwritten.

Behaviour:
- Reset (rst_n low at an edge): state OFF; sample 0; ch_sel 0; dac_code 0; busy 0; result 0; result_ch 0; result_valid 0; overrun 0. Applies from any state, mid-conversion included.
- States: OFF, SAMPLE, CONVERT, DONE.
- OFF -> SAMPLE: en=1, start=1 and ch_mask!=0 at an edge.
  - Latch mask and cont.
  - ch_sel = lowest set bit of the mask.
  - start with ch_mask==0 is ignored.
- SAMPLE:
  - sample=1 and dac_code=0 for exactly SAMPLE_CYCLES cycles, then CONVERT.
  - Bit index k = WIDTH-1; dac_code = resolved bits | (1<<k).
- CONVERT: one cycle per bit, MSB first.
  - At the edge ending the cycle for bit k: bit k stays set if cmp=1, else cleared.
  - Then k decrements and the next trial bit is set.
  - After k=0 is resolved, go to DONE.
  - cmp is only sampled in CONVERT.
- DONE (1 cycle), entered on the edge that resolves bit 0:
  - On that same edge: result = final code, result_ch = ch_sel, result_valid = 1.
  - If result_valid was already 1 and not handshaken on that edge, overrun is set.
- Transition out of DONE:
  - Next set mask bit above ch_sel exists: ch_sel advances to it, go to SAMPLE.
  - Else if cont: wrap to the lowest set bit, go to SAMPLE.
  - Else: OFF, and ch_sel holds.
- Latency: result_valid rises SAMPLE_CYCLES+WIDTH edges after the accepting start edge.
- Throughput: SAMPLE_CYCLES+WIDTH+1 cycles per channel.
- Handshake:
  - result_valid&result_ready at an edge clears result_valid.
  - A new result loaded on the same edge wins: valid stays 1 and no overrun is flagged.
  - result/result_ch are stable while valid is high unless overwritten.
- overrun clears only on reset or on the edge accepting a new start.
- en low at any edge: next state OFF, sample 0, dac_code 0.
  - The in-flight conversion is discarded; result/result_valid are unchanged.
- start while busy is ignored. Changing ch_mask or cont while busy has no effect.
- dac_code is registered; cmp must be settled by the end of each CONVERT cycle.

Test Plan:
- Setup for all scenarios: WIDTH=8, NCH=4, SAMPLE_CYCLES=2. The comparator model returns cmp = (vin_code >= dac_code).
- Single conversion:
  - Stimulus: mask=0001, vin=0xA5, start pulse.
  - Required: sample high 2 cycles; dac_code sequence 80,C0,A0,B0,A8,A4,A6,A5.
  - Required: result=0xA5, result_ch=0, result_valid rising 10 edges after start; then OFF, busy 0.
- Extremes:
  - vin=0x00 -> result 0x00.
  - vin=0xFF -> result 0xFF.
  - vin=0x80 -> result 0x80.
- Scan:
  - Stimulus: mask=1010, single, ready held 1, vin ch1=0x12 / ch3=0xE7.
  - Required: results (ch1,0x12) then (ch3,0xE7), each valid 1 cycle, 11 cycles apart; then OFF.
- Continuous/overrun:
  - Stimulus: mask=0001, cont=1, ready=0.
  - Required: second result overwrites the first, overrun=1, conversions continue.
  - Required: en=0 -> OFF within 1 edge; a new start clears overrun.
- Abort/reset:
  - en=0 during CONVERT: OFF, dac_code 0, prior result and valid preserved.
  - rst_n=0 during SAMPLE: all outputs at reset values on the next edge.
- Ignored inputs:
  - start with mask=0000 -> stays OFF.
  - start while busy -> no restart; scan order unchanged.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample/convert sequencing, masked channel scan,
// and a valid/ready result port with sticky overrun.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int NCH           = 4,
    parameter int SAMPLE_CYCLES = 2,
    localparam int CHW          = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int KW           = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_start,
    input  logic             i_cont,
    input  logic [NCH-1:0]   i_ch_mask,
    input  logic             i_cmp,
    output logic             o_sample,
    output logic [CHW-1:0]   o_ch_sel,
    output logic [WIDTH-1:0] o_dac_code,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_result,
    output logic [CHW-1:0]   o_result_ch,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_overrun
);

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [7:0]       CNT_LAST = 8'(SAMPLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0]    K_MSB    = KW'(WIDTH - 1);

    state_t           r_state;
    logic [NCH-1:0]   r_mask;
    logic             r_cont;
    logic [7:0]       r_cnt;
    logic [KW-1:0]    r_k;
    logic             r_sample;
    logic [CHW-1:0]   r_ch_sel;
    logic [WIDTH-1:0] r_dac_code;
    logic [WIDTH-1:0] r_result;
    logic [CHW-1:0]   r_result_ch;
    logic             r_result_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_trial;
    logic [WIDTH-1:0] w_resolved;
    logic [CHW:0]     w_next;

    function automatic logic [CHW-1:0] f_lowest(input logic [NCH-1:0] m);
        logic [CHW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) idx = CHW'(i);
        end
        return idx;
    endfunction

    // Returns {found, index} of the lowest set mask bit strictly above cur.
    function automatic logic [CHW:0] f_next_above(input logic [NCH-1:0] m, input logic [CHW-1:0] cur);
        logic [CHW:0] res;
        res = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) res = {1'b1, CHW'(i)};
        end
        return res;
    endfunction

    assign w_trial    = W_ONE << r_k;
    assign w_resolved = i_cmp ? r_dac_code : (r_dac_code & ~w_trial);
    assign w_next     = f_next_above(r_mask, r_ch_sel);

    // Controller state, DAC trial register and result port.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= S_OFF;
            r_mask         <= '0;
            r_cont         <= 1'b0;
            r_cnt          <= 8'd0;
            r_k            <= '0;
            r_sample       <= 1'b0;
            r_ch_sel       <= '0;
            r_dac_code     <= '0;
            r_result       <= '0;
            r_result_ch    <= '0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (r_result_valid && i_result_ready) r_result_valid <= 1'b0;

            if (!i_en) begin
                r_state    <= S_OFF;
                r_sample   <= 1'b0;
                r_dac_code <= '0;
            end else begin
                case (r_state)
                    S_OFF: begin
                        if (i_start && (i_ch_mask != '0)) begin
                            r_mask     <= i_ch_mask;
                            r_cont     <= i_cont;
                            r_ch_sel   <= f_lowest(i_ch_mask);
                            r_overrun  <= 1'b0;
                            r_state    <= S_SAMPLE;
                            r_sample   <= 1'b1;
                            r_dac_code <= '0;
                            r_cnt      <= 8'd0;
                        end
                    end
                    S_SAMPLE: begin
                        if (r_cnt == CNT_LAST) begin
                            r_state    <= S_CONVERT;
                            r_sample   <= 1'b0;
                            r_dac_code <= W_ONE << K_MSB;
                            r_k        <= K_MSB;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_CONVERT: begin
                        if (r_k == '0) begin
                            r_state        <= S_DONE;
                            r_dac_code     <= w_resolved;
                            r_result       <= w_resolved;
                            r_result_ch    <= r_ch_sel;
                            r_result_valid <= 1'b1;
                            if (r_result_valid && !i_result_ready) r_overrun <= 1'b1;
                        end else begin
                            r_dac_code <= w_resolved | (W_ONE << (r_k - KW'(1)));
                            r_k        <= r_k - KW'(1);
                        end
                    end
                    S_DONE: begin
                        r_dac_code <= '0;
                        r_cnt      <= 8'd0;
                        if (w_next[CHW]) begin
                            r_ch_sel <= w_next[CHW-1:0];
                            r_state  <= S_SAMPLE;
                            r_sample <= 1'b1;
                        end else if (r_cont) begin
                            r_ch_sel <= f_lowest(r_mask);
                            r_state  <= S_SAMPLE;
                            r_sample <= 1'b1;
                        end else begin
                            r_state  <= S_OFF;
                        end
                    end
                    default: begin
                        r_state    <= S_OFF;
                        r_sample   <= 1'b0;
                        r_dac_code <= '0;
                    end
                endcase
            end
        end
    end

    assign o_sample       = r_sample;
    assign o_ch_sel       = r_ch_sel;
    assign o_dac_code     = r_dac_code;
    assign o_busy         = (r_state != S_OFF);
    assign o_result       = r_result;
    assign o_result_ch    = r_result_ch;
    assign o_result_valid = r_result_valid;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: comparator model on per-channel input codes,
// directed scenarios plus randomized single-shot scans.
module tb_sar_adc_ctrl;
    localparam int W = 8;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] ch_mask = 4'd0;
    logic       cmp;
    logic       sample;
    logic [1:0] ch_sel;
    logic [7:0] dac_code;
    logic       busy;
    logic [7:0] result;
    logic [1:0] result_ch;
    logic       result_valid;
    logic       result_ready = 1'b0;
    logic       overrun;

    logic [7:0] vin [4];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign cmp = (vin[ch_sel] >= dac_code);

    sar_adc_ctrl #(.WIDTH(W), .NCH(4), .SAMPLE_CYCLES(S)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_cont(cont),
        .i_ch_mask(ch_mask), .i_cmp(cmp), .o_sample(sample), .o_ch_sel(ch_sel),
        .o_dac_code(dac_code), .o_busy(busy), .o_result(result), .o_result_ch(result_ch),
        .o_result_valid(result_valid), .i_result_ready(result_ready), .o_overrun(overrun)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive a start pulse for one edge; returns at the first SAMPLE cycle.
    task automatic do_start(input logic [3:0] m, input logic c);
        start = 1'b1; ch_mask = m; cont = c;
        tick();
        start = 1'b0;
    endtask

    // Checks one channel's sample window and bit-by-bit trials; ends in DONE.
    task automatic conv_check(input int ch, input logic pre_v);
        logic [7:0] code;
        logic [7:0] trial;
        logic [7:0] v;
        v = vin[ch];
        code = 8'd0;
        for (int i = 0; i < S; i++) begin
            chk("sample_hi", sample, 1);
            chk("sample_dac", dac_code, 0);
            chk("ch_sel", ch_sel, ch);
            tick();
        end
        for (int k = W - 1; k >= 0; k--) begin
            trial = code | (8'd1 << k);
            chk("trial_code", dac_code, trial);
            chk("conv_sample_lo", sample, 0);
            if (k == 0) chk("pre_valid", result_valid, pre_v);
            if (v >= trial) code = trial;
            tick();
        end
        chk("result", result, v);
        chk("result_ch", result_ch, ch);
        chk("result_valid", result_valid, 1);
    endtask

    initial begin
        logic [7:0] ext [3];
        logic [3:0] m;
        bit first;
        ext[0] = 8'h00; ext[1] = 8'hFF; ext[2] = 8'h80;
        for (int i = 0; i < 4; i++) vin[i] = 8'h00;

        tick(); tick();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_dac", dac_code, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_overrun", overrun, 0);

        // start with an empty mask is ignored
        do_start(4'b0000, 1'b0);
        tick();
        chk("empty_mask_busy", busy, 0);

        // single conversion, result held until consumed
        vin[0] = 8'hA5;
        do_start(4'b0001, 1'b0);
        chk("single_busy", busy, 1);
        conv_check(0, 1'b0);
        tick();
        chk("single_off", busy, 0);
        chk("single_hold", result_valid, 1);
        chk("single_hold_res", result, 8'hA5);
        result_ready = 1'b1;
        tick();
        chk("single_consumed", result_valid, 0);

        // extreme codes on varying channels
        for (int i = 0; i < 3; i++) begin
            vin[i] = ext[i];
            do_start(4'd1 << i, 1'b0);
            conv_check(i, 1'b0);
            tick();
            chk("ext_off", busy, 0);
            chk("ext_valid_1cyc", result_valid, 0);
        end

        // two-channel scan; start/mask/cont changes while busy are ignored
        vin[1] = 8'h12; vin[3] = 8'hE7;
        do_start(4'b1010, 1'b0);
        start = 1'b1; ch_mask = 4'b0001; cont = 1'b1;
        conv_check(1, 1'b0);
        tick();
        chk("scan_valid_1cyc", result_valid, 0);
        conv_check(3, 1'b0);
        tick();
        chk("scan_off", busy, 0);
        start = 1'b0; cont = 1'b0;

        // randomized single-shot scans
        for (int r = 0; r < 4; r++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) vin[i] = 8'($urandom_range(0, 255));
            do_start(m, 1'b0);
            first = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (m[c]) begin
                    if (!first) tick();
                    conv_check(c, 1'b0);
                    first = 1'b0;
                end
            end
            tick();
            chk("rand_off", busy, 0);
        end

        // continuous mode with consumer stalled: overwrite flags overrun
        result_ready = 1'b0;
        vin[0] = 8'h3C;
        do_start(4'b0001, 1'b1);
        conv_check(0, 1'b0);
        chk("cont_no_ovr", overrun, 0);
        tick();
        chk("cont_busy", busy, 1);
        vin[0] = 8'hC3;
        conv_check(0, 1'b1);
        chk("cont_ovr", overrun, 1);
        tick();
        chk("cont_continues", sample, 1);
        en = 1'b0;
        tick();
        chk("en_off_busy", busy, 0);
        chk("en_off_sample", sample, 0);
        chk("en_off_ovr_sticky", overrun, 1);
        en = 1'b1;
        result_ready = 1'b1;
        vin[2] = 8'h5A;
        do_start(4'b0100, 1'b0);
        chk("start_clr_ovr", overrun, 0);
        conv_check(2, 1'b0);
        tick();

        // abort mid-conversion keeps prior result
        result_ready = 1'b0;
        vin[0] = 8'h77; vin[1] = 8'h99;
        do_start(4'b0001, 1'b0);
        conv_check(0, 1'b0);
        tick();
        do_start(4'b0010, 1'b0);
        tick(); tick(); tick();
        chk("abort_in_convert", dac_code, 8'hC0);
        en = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_dac", dac_code, 0);
        chk("abort_valid", result_valid, 1);
        chk("abort_result", result, 8'h77);
        chk("abort_result_ch", result_ch, 0);
        en = 1'b1;

        // reset during sample
        do_start(4'b0100, 1'b0);
        chk("pre_rst_ch", ch_sel, 2);
        rst_n = 1'b0;
        tick();
        chk("rst2_sample", sample, 0);
        chk("rst2_ch_sel", ch_sel, 0);
        chk("rst2_dac", dac_code, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_result", result, 0);
        chk("rst2_result_ch", result_ch, 0);
        chk("rst2_valid", result_valid, 0);
        chk("rst2_overrun", overrun, 0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
